// File: rtl/audio_ctrl_pkg.sv
// Shared constants for the front-panel audio parameter controls.
package audio_ctrl_pkg;

  localparam int PARAM_W    = 8;
  localparam int NUM_PARAMS = 4;

  localparam int PARAM_GAIN = 0;
  localparam int PARAM_MIX  = 1;
  localparam int PARAM_FB   = 2;
  localparam int PARAM_RATE = 3;

  localparam int RL_EVENT = 1;
  localparam int RL_LEFT  = 0;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer.
// btn_rise pulses for one cycle on an accepted press.
module btn_debounce #(
  parameter int DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] C_END = CW'(DEBOUNCE - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
    end else begin
      s1       <= btn_raw;
      s2       <= s1;
      btn_rise <= 1'b0;
      // count only while the synced input disagrees with the accepted state
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == C_END) begin
        cnt       <= '0;
        btn_level <= s2;
        btn_rise  <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rot_param_ctrl.sv
// Rotary-encoder driven bank of saturating effect parameters
// with button-selected target and spin acceleration.
module rot_param_ctrl #(
  parameter int WIDTH       = audio_ctrl_pkg::PARAM_W,
  parameter int NUM_PARAMS  = audio_ctrl_pkg::NUM_PARAMS,
  parameter int INIT_VAL    = 128,
  parameter int STEP        = 1,
  parameter int FAST_STEP   = 8,
  parameter int FAST_WINDOW = 500000,
  parameter int DEBOUNCE    = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    rlrot,
  input  logic                          btn,
  output logic [$clog2(NUM_PARAMS)-1:0] param_sel,
  output logic [WIDTH-1:0]              param_val,
  output logic [NUM_PARAMS*WIDTH-1:0]   param_bus,
  output logic                          upd
);

  import audio_ctrl_pkg::*;

  localparam int SW = $clog2(NUM_PARAMS);
  localparam int TW = $clog2(FAST_WINDOW + 1);
  localparam logic [TW-1:0]    T_MAX = TW'(FAST_WINDOW);
  localparam logic [WIDTH:0]   V_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [SW-1:0]    S_END = SW'(NUM_PARAMS - 1);
  localparam logic [WIDTH-1:0] V_INI = WIDTH'(INIT_VAL);

  logic             btn_level;
  logic             sel_adv;
  logic             sel_go;
  logic [WIDTH-1:0] prm [NUM_PARAMS];
  logic [TW-1:0]    timer;
  logic             ev;
  logic             left;
  logic [WIDTH:0]   step;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             chg;

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_db (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn),
    .btn_level (btn_level),
    .btn_rise  (sel_adv)
  );

  assign sel_go = sel_adv & btn_level;

  always_comb begin
    ev   = rlrot[RL_EVENT];
    left = rlrot[RL_LEFT];
    step = (timer < T_MAX) ? (WIDTH+1)'(FAST_STEP)
                           : (WIDTH+1)'(STEP);
    cur  = prm[param_sel];
    sum  = {1'b0, cur} + step;
    res  = cur;
    if (left) begin
      res = ({1'b0, cur} < step) ? '0
          : WIDTH'({1'b0, cur} - step);
    end else begin
      res = (sum > V_MAX) ? WIDTH'(V_MAX) : sum[WIDTH-1:0];
    end
    chg = ev && (res != cur);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PARAMS; i++) prm[i] <= V_INI;
      param_sel <= '0;
      upd       <= 1'b0;
      timer     <= T_MAX;
    end else begin
      upd <= chg;
      if (chg) prm[param_sel] <= res;
      if (ev) begin
        timer <= '0;
      end else if (timer < T_MAX) begin
        timer <= timer + 1'b1;
      end
      // an event on this edge still lands on the old selection
      if (sel_go) begin
        param_sel <= (param_sel == S_END) ? '0 : param_sel + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_bus
    assign param_bus[g*WIDTH +: WIDTH] = prm[g];
  end

  assign param_val = prm[param_sel];

endmodule
